// File: rtl/gp_pkg.sv
// Shared graphics-processor definitions: opcodes, coordinate widths and the
// arbiter state encoding, reused by the requesters and the processor.
package gp_pkg;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_BLIT = 1'b1;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int ARG_W = 12;
  localparam int CNT_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Index width for a requester count in the legal 2..4 range.
  function automatic int idx_w(input int n);
    if (n > 2) begin
      return 2;
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/gp_arbiter_if.sv
// Requester-side and processor-side signals of the graphics arbiter.
// The arbiter uses the slave view; the environment drives through master.
interface gp_arbiter_if #(parameter int NUM_REQ = 2);
  import gp_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       req_opcode;
  logic [X_W*NUM_REQ-1:0]   req_tl_x;
  logic [X_W*NUM_REQ-1:0]   req_br_x;
  logic [Y_W*NUM_REQ-1:0]   req_tl_y;
  logic [Y_W*NUM_REQ-1:0]   req_br_y;
  logic [ARG_W*NUM_REQ-1:0] req_arg;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     timeout_err;
  logic                     busy;
  logic                     gp_en;
  logic                     gp_opcode;
  logic [X_W-1:0]           gp_tl_x;
  logic [Y_W-1:0]           gp_tl_y;
  logic [X_W-1:0]           gp_br_x;
  logic [Y_W-1:0]           gp_br_y;
  logic [ARG_W-1:0]         gp_arg;
  logic                     gp_finish;

  modport slave (
    input  req, req_opcode, req_tl_x, req_br_x, req_tl_y, req_br_y, req_arg, gp_finish,
    output grant, done, timeout_err, busy, gp_en,
           gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg
  );

  modport master (
    output req, req_opcode, req_tl_x, req_br_x, req_tl_y, req_br_y, req_arg, gp_finish,
    input  grant, done, timeout_err, busy, gp_en,
           gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg
  );

endinterface

// File: rtl/gp_rr_picker.sv
// Combinational round-robin picker: first set request after index last_i,
// wrapping modulo NUM_REQ.
module gp_rr_picker
  import gp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] winner_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;

  // Bit j of rot_s is the request (last_i+1+j) mod NUM_REQ.
  assign dbl_s = {req_i, req_i};
  assign rot_s = NUM_REQ'(dbl_s >> (int'(last_i) + 1));

  // Priority scan over the rotated vector, then map back to an absolute index.
  always_comb begin
    int   pos;
    logic found;
    pos   = 0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (rot_s[j] && !found) begin
        found = 1'b1;
        pos   = int'(last_i) + 1 + j;
      end else begin
        pos = pos;
      end
    end
    if (pos >= NUM_REQ) begin
      pos = pos - NUM_REQ;
    end else begin
      pos = pos;
    end
    idx_o    = IDX_W'(pos);
    winner_o = found ? (NUM_REQ'(1'b1) << idx_o) : '0;
  end

endmodule

// File: rtl/gp_arbiter.sv
// Round-robin owner of the single graphics_processor command port: latches the
// winning command, strobes gp_en, waits for gp_finish under a watchdog.
module gp_arbiter
  import gp_pkg::*;
#(
  parameter int               NUM_REQ = 2,
  parameter logic [CNT_W-1:0] TIMEOUT = 20'hFFFFF
) (
  input logic         clk,
  input logic         rst_n,
  gp_arbiter_if.slave bus
);

  localparam int               IDX_W    = idx_w(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT - 20'd1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d, own_q, own_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, done_q, done_d;
  logic               terr_q, terr_d, busy_q, busy_d, gp_en_q, gp_en_d;
  logic               op_q, op_d;
  logic [X_W-1:0]     tlx_q, tlx_d, brx_q, brx_d;
  logic [Y_W-1:0]     tly_q, tly_d, bry_q, bry_d;
  logic [ARG_W-1:0]   arg_q, arg_d;
  logic [NUM_REQ-1:0] win_s;
  logic [IDX_W-1:0]   win_idx_s;

  gp_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i    (bus.req),
    .last_i   (last_q),
    .winner_o (win_s),
    .idx_o    (win_idx_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a finish outside WAIT never reaches DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|bus.req) state_d = ST_ISSUE; else state_d = ST_IDLE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.gp_finish || (cnt_q == CNT_LAST)) state_d = ST_DONE;
                else state_d = ST_WAIT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, command latch and watchdog.
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    terr_d  = 1'b0;
    gp_en_d = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    last_d  = last_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tlx_d   = tlx_q;
    tly_d   = tly_q;
    brx_d   = brx_q;
    bry_d   = bry_q;
    arg_d   = arg_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          grant_d = win_s;
          gp_en_d = 1'b1;
          own_d   = win_idx_s;
          op_d    = bus.req_opcode[win_idx_s];
          tlx_d   = bus.req_tl_x[int'(win_idx_s)*X_W +: X_W];
          tly_d   = bus.req_tl_y[int'(win_idx_s)*Y_W +: Y_W];
          brx_d   = bus.req_br_x[int'(win_idx_s)*X_W +: X_W];
          bry_d   = bus.req_br_y[int'(win_idx_s)*Y_W +: Y_W];
          arg_d   = bus.req_arg[int'(win_idx_s)*ARG_W +: ARG_W];
        end else begin
          grant_d = '0;
        end
      end
      ST_ISSUE: cnt_d = '0;
      ST_WAIT: begin
        // A finish on the last watchdog cycle still counts as a normal completion.
        if (state_d == ST_DONE) begin
          done_d = grant_q;
          terr_d = ~bus.gp_finish;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        last_d  = own_q;
      end
      default: grant_d = '0;
    endcase
  end

  // Output, command and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      done_q  <= '0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
      gp_en_q <= 1'b0;
      last_q  <= LAST_RST;
      own_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      tlx_q   <= '0;
      tly_q   <= '0;
      brx_q   <= '0;
      bry_q   <= '0;
      arg_q   <= '0;
    end else begin
      grant_q <= grant_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      busy_q  <= busy_d;
      gp_en_q <= gp_en_d;
      last_q  <= last_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tlx_q   <= tlx_d;
      tly_q   <= tly_d;
      brx_q   <= brx_d;
      bry_q   <= bry_d;
      arg_q   <= arg_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = busy_q;
  assign bus.gp_en       = gp_en_q;
  assign bus.gp_opcode   = op_q;
  assign bus.gp_tl_x     = tlx_q;
  assign bus.gp_tl_y     = tly_q;
  assign bus.gp_br_x     = brx_q;
  assign bus.gp_br_y     = bry_q;
  assign bus.gp_arg      = arg_q;

endmodule

// File: tb/tb_gp_arbiter.sv
// Bench for gp_arbiter: directed scenarios plus random traffic, checked every
// cycle against a transaction-age model of the arbiter.
module tb_gp_arbiter;
  import gp_pkg::*;

  localparam int               N  = 3;
  localparam logic [CNT_W-1:0] TO = 20'd100;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  // Model: owner (-1 when idle), age since gp_en, age of the done pulse.
  int             m_owner, m_age, m_done_at, m_last;
  logic           m_tmo, m_op;
  logic [X_W-1:0] m_tlx, m_brx;
  logic [Y_W-1:0] m_tly, m_bry;
  logic [ARG_W-1:0] m_arg;

  logic [N-1:0] exp_seq [4];

  gp_arbiter_if #(.NUM_REQ(N)) bus ();

  gp_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_done_at = -1; m_last = N - 1; m_tmo = 1'b0;
    m_op = 1'b0; m_tlx = '0; m_brx = '0; m_tly = '0; m_bry = '0; m_arg = '0;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int j = 1; j <= N; j++) begin
      int k;
      k = (m_last + j) % N;
      if (r[k] === 1'b1) return k;
    end
    return -1;
  endfunction

  // Advance the model by one clock using the inputs the DUT is about to sample.
  task automatic model_step();
    int w;
    if (m_owner < 0) begin
      w = pick(bus.req);
      if (w >= 0) begin
        m_owner = w; m_age = 0; m_done_at = -1; m_tmo = 1'b0;
        m_op  = bus.req_opcode[w];
        m_tlx = bus.req_tl_x[w*X_W +: X_W];
        m_tly = bus.req_tl_y[w*Y_W +: Y_W];
        m_brx = bus.req_br_x[w*X_W +: X_W];
        m_bry = bus.req_br_y[w*Y_W +: Y_W];
        m_arg = bus.req_arg[w*ARG_W +: ARG_W];
      end
    end else if (m_age == m_done_at) begin
      m_last  = m_owner;
      m_owner = -1;
    end else begin
      if (m_done_at < 0 && m_age >= 1) begin
        if (bus.gp_finish === 1'b1) begin
          m_done_at = m_age + 1;
        end else if (m_age == int'(TO)) begin
          m_done_at = m_age + 1;
          m_tmo     = 1'b1;
        end
      end
      m_age++;
    end
  endtask

  task automatic compare();
    logic [N-1:0] oh, dn;
    oh = '0;
    dn = '0;
    if (m_owner >= 0) oh = N'(1'b1) << m_owner;
    if (m_owner >= 0 && m_age == m_done_at) dn = oh;
    chk("grant",       32'(bus.grant),       32'(oh));
    chk("done",        32'(bus.done),        32'(dn));
    chk("timeout_err", 32'(bus.timeout_err), 32'((dn != '0) && m_tmo));
    chk("busy",        32'(bus.busy),        32'(m_owner >= 0));
    chk("gp_en",       32'(bus.gp_en),       32'((m_owner >= 0) && (m_age == 0)));
    chk("gp_opcode",   32'(bus.gp_opcode),   32'(m_op));
    chk("gp_tl_x",     32'(bus.gp_tl_x),     32'(m_tlx));
    chk("gp_tl_y",     32'(bus.gp_tl_y),     32'(m_tly));
    chk("gp_br_x",     32'(bus.gp_br_x),     32'(m_brx));
    chk("gp_br_y",     32'(bus.gp_br_y),     32'(m_bry));
    chk("gp_arg",      32'(bus.gp_arg),      32'(m_arg));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic set_cmd(input int i, input logic op, input logic [X_W-1:0] x0,
                         input logic [Y_W-1:0] y0, input logic [X_W-1:0] x1,
                         input logic [Y_W-1:0] y1, input logic [ARG_W-1:0] a);
    bus.req_opcode[i]            = op;
    bus.req_tl_x[i*X_W +: X_W]   = x0;
    bus.req_tl_y[i*Y_W +: Y_W]   = y0;
    bus.req_br_x[i*X_W +: X_W]   = x1;
    bus.req_br_y[i*Y_W +: Y_W]   = y1;
    bus.req_arg[i*ARG_W +: ARG_W] = a;
  endtask

  task automatic rand_cmd(input int i);
    set_cmd(i, 1'($urandom), 10'($urandom), 9'($urandom), 10'($urandom), 9'($urandom),
            12'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0; bus.req_opcode = '0; bus.req_tl_x = '0; bus.req_br_x = '0;
    bus.req_tl_y = '0; bus.req_br_y = '0; bus.req_arg = '0; bus.gp_finish = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare();
  endtask

  task automatic wait_en(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.gp_en === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("gp_en_wait", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (bus.done !== '0) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("done_wait", 32'd0, 32'd1);
  endtask

  initial begin
    int e, d, base;
    logic [N-1:0] g;
    logic stuck;
    checks = 0; errors = 0; cyc = 0;
    exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001; exp_seq[3] = 3'b010;
    model_reset();
    do_reset();
    chk("rst_grant", 32'(bus.grant), 32'd0);

    // Single fill from requester 0, finish in cycle 20.
    set_cmd(0, OP_FILL, 10'd0, 9'd0, 10'd9, 9'd9, 12'hF00);
    bus.req = 3'b001;
    base = cyc;
    tick();
    chk("t1_gp_en", 32'(bus.gp_en), 32'd1);
    chk("t1_grant", 32'(bus.grant), 32'd1);
    chk("t1_br_x", 32'(bus.gp_br_x), 32'd9);
    chk("t1_arg", 32'(bus.gp_arg), 32'hF00);
    while (cyc - base < 20) tick();
    bus.gp_finish = 1'b1;
    tick();
    bus.gp_finish = 1'b0;
    chk("t1_done_c21", 32'(bus.done), 32'd1);
    chk("t1_terr", 32'(bus.timeout_err), 32'd0);
    bus.req = '0;
    repeat (2) tick();

    // Two continuous requesters alternate.
    do_reset();
    rand_cmd(1);
    bus.req = 3'b011;
    for (int t = 0; t < 4; t++) begin
      wait_en(20, e);
      g = bus.grant;
      chk("t2_grant_seq", 32'(g), 32'(exp_seq[t]));
      repeat (5) tick();
      bus.gp_finish = 1'b1;
      tick();
      bus.gp_finish = 1'b0;
      chk("t2_done", 32'(bus.done), 32'(g));
    end
    bus.req = '0;
    repeat (2) tick();

    // Stuck processor: watchdog abandon, then the next request is served.
    rand_cmd(2);
    bus.req = 3'b100;
    wait_en(20, e);
    wait_done(200, d);
    chk("t3_latency", 32'(d - e), 32'd101);
    chk("t3_terr", 32'(bus.timeout_err), 32'd1);
    bus.req = 3'b001;
    wait_en(10, e);
    chk("t3_next_grant", 32'(bus.grant), 32'd1);
    repeat (2) tick();
    bus.gp_finish = 1'b1;
    tick();
    bus.gp_finish = 1'b0;
    bus.req = '0;
    repeat (3) tick();

    // Finish in IDLE and ISSUE is ignored.
    bus.gp_finish = 1'b1;
    tick();
    chk("t4_idle_done", 32'(bus.done), 32'd0);
    chk("t4_idle_busy", 32'(bus.busy), 32'd0);
    bus.req = 3'b010;
    tick();
    tick();
    bus.gp_finish = 1'b0;
    chk("t4_issue_done", 32'(bus.done), 32'd0);
    chk("t4_wait_busy", 32'(bus.busy), 32'd1);
    repeat (3) tick();
    bus.gp_finish = 1'b1;
    tick();
    bus.gp_finish = 1'b0;
    chk("t4_done", 32'(bus.done), 32'b010);
    bus.req = '0;
    tick();

    // Asynchronous reset in the middle of WAIT.
    rand_cmd(0);
    bus.req = 3'b001;
    wait_en(10, e);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_grant", 32'(bus.grant), 32'd0);
    chk("t5_busy", 32'(bus.busy), 32'd0);
    chk("t5_gp_en", 32'(bus.gp_en), 32'd0);
    chk("t5_done", 32'(bus.done), 32'd0);
    chk("t5_tl_x", 32'(bus.gp_tl_x), 32'd0);
    chk("t5_arg", 32'(bus.gp_arg), 32'd0);
    @(negedge clk);
    bus.req = 3'b011;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare();
    tick();
    chk("t5_first_grant", 32'(bus.grant), 32'd1);
    tick();
    bus.gp_finish = 1'b1;
    tick();
    bus.gp_finish = 1'b0;
    chk("t5_done_after", 32'(bus.done), 32'd1);
    bus.req = '0;
    repeat (2) tick();

    // Owner drops req and changes its fields mid-WAIT.
    set_cmd(2, OP_BLIT, 10'd100, 9'd50, 10'd300, 9'd200, 12'h5A5);
    bus.req = 3'b100;
    wait_en(10, e);
    repeat (2) tick();
    bus.req = '0;
    set_cmd(2, OP_FILL, 10'd0, 9'd0, 10'd0, 9'd0, 12'h000);
    repeat (4) tick();
    chk("t6_op", 32'(bus.gp_opcode), 32'd1);
    chk("t6_tl_x", 32'(bus.gp_tl_x), 32'd100);
    chk("t6_br_y", 32'(bus.gp_br_y), 32'd200);
    chk("t6_arg", 32'(bus.gp_arg), 32'h5A5);
    bus.gp_finish = 1'b1;
    tick();
    bus.gp_finish = 1'b0;
    chk("t6_done", 32'(bus.done), 32'b100);
    tick();

    // Random traffic against the model.
    stuck = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) stuck = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (bus.done[i] === 1'b1) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
        end else if (bus.req[i] == 1'b0 && $urandom_range(0, 5) == 0) begin
          bus.req[i] = 1'b1;
          rand_cmd(i);
        end else if (bus.req[i] == 1'b1 && $urandom_range(0, 99) == 0) begin
          bus.req[i] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) rand_cmd(i);
      end
      bus.gp_finish = !stuck && ($urandom_range(0, 9) == 0);
      tick();
    end
    bus.req = '0;
    bus.gp_finish = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
